// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: allocates RobIds at issue, absorbs CDB results, retires the head in order.
// Optional ROB_CDB_BYPASS_EN forwards a same-cycle CDB result onto the operand query ports.
module reorder_buffer #(
  parameter int ROB_LOG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               rdy,
  input  logic               issue_valid,
  input  logic [4:0]         issue_rd,
  output logic [ROB_LOG-1:0] issue_RobId,
  output logic               rob_full,
  input  logic               cdb_valid,
  input  logic [ROB_LOG-1:0] cdb_RobId,
  input  logic [31:0]        cdb_value,
  input  logic               cdb_jump,
  input  logic [31:0]        cdb_target,
  input  logic [ROB_LOG-1:0] query_j_id,
  output logic               query_j_ready,
  output logic [31:0]        query_j_value,
  input  logic [ROB_LOG-1:0] query_k_id,
  output logic               query_k_ready,
  output logic [31:0]        query_k_value,
  output logic               commit_valid,
  output logic [4:0]         commit_dest,
  output logic [31:0]        commit_value,
  output logic [ROB_LOG-1:0] commit_RobId,
  output logic               jump_flag,
  output logic [31:0]        jump_pc
);

  localparam int N = 2 ** ROB_LOG;
  localparam logic [ROB_LOG:0] FULL_CNT = (ROB_LOG + 1)'(N);

  logic [N-1:0]       busy, ready, jump;
  logic [4:0]         dest   [N];
  logic [31:0]        value  [N];
  logic [31:0]        target [N];
  logic [ROB_LOG-1:0] head, tail;
  logic [ROB_LOG:0]   count;

  logic head_done, do_issue, do_wb, do_commit, do_flush;

  assign issue_RobId = tail;
  assign rob_full    = (count == FULL_CNT);

  // count guard keeps stale ready bits at an empty head from retiring
  assign head_done = busy[head] && ready[head] && (count != '0);
  assign do_commit = rdy && head_done;
  assign do_flush  = do_commit && jump[head];
  assign do_issue  = rdy && issue_valid && !rob_full && !jump_flag;
  assign do_wb     = rdy && cdb_valid && busy[cdb_RobId] && !jump_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= '0;
      ready        <= '0;
      jump         <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_dest  <= '0;
      commit_value <= '0;
      commit_RobId <= '0;
      jump_flag    <= 1'b0;
      jump_pc      <= '0;
    end else if (rdy) begin
      commit_valid <= head_done;
      jump_flag    <= do_flush;
      if (head_done) begin
        commit_dest  <= dest[head];
        commit_value <= value[head];
        commit_RobId <= head;
      end
      if (do_flush) begin
        jump_pc <= target[head];
        busy    <= '0;
        ready   <= '0;
        jump    <= '0;
        head    <= '0;
        tail    <= '0;
        count   <= '0;
      end else begin
        if (do_wb) begin
          ready[cdb_RobId] <= 1'b1;
          jump[cdb_RobId]  <= cdb_jump;
        end
        if (do_issue) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= 1'b0;
          jump[tail]  <= 1'b0;
          tail        <= tail + 1'b1;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
        end
        count <= count + (ROB_LOG + 1)'(do_issue) - (ROB_LOG + 1)'(do_commit);
      end
    end
  end

  // payload is qualified by busy/ready, so it needs no reset
  always_ff @(posedge clk) begin
    if (do_issue) dest[tail] <= issue_rd;
    if (do_wb) begin
      value[cdb_RobId]  <= cdb_value;
      target[cdb_RobId] <= cdb_target;
    end
  end

  logic j_hit, k_hit;
  assign j_hit = busy[query_j_id] && ready[query_j_id];
  assign k_hit = busy[query_k_id] && ready[query_k_id];

`ifdef ROB_CDB_BYPASS_EN
  logic j_byp, k_byp;
  assign j_byp = cdb_valid && (cdb_RobId == query_j_id) && busy[query_j_id];
  assign k_byp = cdb_valid && (cdb_RobId == query_k_id) && busy[query_k_id];
  assign query_j_ready = j_hit || j_byp;
  assign query_k_ready = k_hit || k_byp;
  assign query_j_value = j_hit ? value[query_j_id] : (j_byp ? cdb_value : '0);
  assign query_k_value = k_hit ? value[query_k_id] : (k_byp ? cdb_value : '0);
`else
  assign query_j_ready = j_hit;
  assign query_k_ready = k_hit;
  assign query_j_value = j_hit ? value[query_j_id] : '0;
  assign query_k_value = k_hit ? value[query_k_id] : '0;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios plus randomized traffic checked against a
// program-order queue model of the in-flight instructions.
module tb_reorder_buffer;
  localparam int N = 16;

  logic        clk, rst_n, rdy, issue_valid, cdb_valid, cdb_jump;
  logic [4:0]  issue_rd;
  logic [3:0]  issue_RobId, cdb_RobId, query_j_id, query_k_id, commit_RobId;
  logic [31:0] cdb_value, cdb_target, query_j_value, query_k_value, commit_value, jump_pc;
  logic        rob_full, query_j_ready, query_k_ready, commit_valid, jump_flag;
  logic [4:0]  commit_dest;

  reorder_buffer #(.ROB_LOG(4)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_RobId(issue_RobId), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_RobId(cdb_RobId), .cdb_value(cdb_value),
    .cdb_jump(cdb_jump), .cdb_target(cdb_target),
    .query_j_id(query_j_id), .query_j_ready(query_j_ready), .query_j_value(query_j_value),
    .query_k_id(query_k_id), .query_k_ready(query_k_ready), .query_k_value(query_k_value),
    .commit_valid(commit_valid), .commit_dest(commit_dest), .commit_value(commit_value),
    .commit_RobId(commit_RobId), .jump_flag(jump_flag), .jump_pc(jump_pc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // in-flight instructions, oldest first
  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
    bit          jmp;
    logic [31:0] tgt;
  } ent_t;
  ent_t        mq[$];
  logic [3:0]  m_tail;
  bit          exp_cv, exp_jf;
  logic [4:0]  exp_dest;
  logic [31:0] exp_val, exp_jpc;
  logic [3:0]  exp_id;

  task automatic model_reset();
    mq.delete();
    m_tail = 0; exp_cv = 0; exp_jf = 0;
    exp_dest = 0; exp_val = 0; exp_id = 0; exp_jpc = 0;
  endtask

  function automatic void qexp(input logic [3:0] id, output bit r, output logic [31:0] v);
    bit inq = 0, dn = 0;
    logic [31:0] dv = 0;
    foreach (mq[i]) if (mq[i].id == id) begin inq = 1; dn = mq[i].done; dv = mq[i].val; end
    r = inq && dn;
    v = r ? dv : 32'h0;
`ifdef ROB_CDB_BYPASS_EN
    if (!r && inq && cdb_valid && cdb_RobId == id) begin r = 1; v = cdb_value; end
`endif
  endfunction

  task automatic drive(input bit iv, input logic [4:0] ird, input bit cv, input logic [3:0] cid,
                       input logic [31:0] cval, input bit cj, input logic [31:0] ctgt);
    issue_valid = iv; issue_rd = ird;
    cdb_valid = cv; cdb_RobId = cid; cdb_value = cval; cdb_jump = cj; cdb_target = ctgt;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  // advances one clock edge and applies the edge to the model
  task automatic tick();
    bit full, jf, do_c, flush;
    ent_t c, e;
    @(posedge clk);
    if (rdy) begin
      full = (mq.size() == N); jf = exp_jf; do_c = 0; flush = 0;
      if (mq.size() > 0 && mq[0].done) begin c = mq.pop_front(); do_c = 1; flush = c.jmp; end
      if (cdb_valid && !jf)
        foreach (mq[i]) if (mq[i].id == cdb_RobId) begin
          mq[i].done = 1; mq[i].val = cdb_value; mq[i].jmp = cdb_jump; mq[i].tgt = cdb_target;
        end
      if (issue_valid && !full && !jf) begin
        e.id = m_tail; e.rd = issue_rd; e.done = 0; e.val = 0; e.jmp = 0; e.tgt = 0;
        mq.push_back(e);
        m_tail = m_tail + 1'b1;
      end
      exp_cv = do_c;
      if (do_c) begin exp_dest = c.rd; exp_val = c.val; exp_id = c.id; end
      exp_jf = flush;
      if (flush) begin exp_jpc = c.tgt; mq.delete(); m_tail = 0; end
    end
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0; rdy = 1; idle();
    model_reset();
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1;
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL reset_commit_valid got=%b exp=0", commit_valid); end
    checks++; if (issue_RobId !== 4'd0) begin failures++; $display("FAIL reset_issue_RobId got=%0d exp=0", issue_RobId); end
    checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_rob_full got=%b exp=0", rob_full); end
    checks++; if (jump_flag !== 1'b0 || query_j_ready !== 1'b0 || query_k_ready !== 1'b0) begin
      failures++; $display("FAIL reset_flags got jf=%b qj=%b qk=%b exp=0", jump_flag, query_j_ready, query_k_ready); end
    rdy = 1; idle();
    model_reset();
    @(negedge clk) rst_n = 1;
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    for (int i = 1; i <= 3; i++) begin drive(1, 5'(i), 0, 0, 0, 0, 0); tick(); end
    checks++; if (issue_RobId !== 4'd3) begin failures++; $display("FAIL ord_tail got=%0d exp=3", issue_RobId); end
    drive(0, 0, 1, 4'd2, 32'h33, 0, 0); tick();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ord_no_commit_id2 got=%b exp=0", commit_valid); end
    drive(0, 0, 1, 4'd0, 32'h11, 0, 0); tick();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ord_latency got=%b exp=0", commit_valid); end
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd1 || commit_value !== 32'h11 || commit_RobId !== 4'd0) begin
      failures++; $display("FAIL ord_commit0 got v=%b d=%0d val=%h id=%0d exp v=1 d=1 val=11 id=0", commit_valid, commit_dest, commit_value, commit_RobId); end
    for (int i = 0; i < 2; i++) begin
      idle(); tick();
      checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ord_wait_id1 got=%b exp=0", commit_valid); end
    end
    drive(0, 0, 1, 4'd1, 32'h22, 0, 0); tick();
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd2 || commit_value !== 32'h22 || commit_RobId !== 4'd1) begin
      failures++; $display("FAIL ord_commit1 got v=%b d=%0d val=%h id=%0d exp v=1 d=2 val=22 id=1", commit_valid, commit_dest, commit_value, commit_RobId); end
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_dest !== 5'd3 || commit_value !== 32'h33 || commit_RobId !== 4'd2) begin
      failures++; $display("FAIL ord_commit2 got v=%b d=%0d val=%h id=%0d exp v=1 d=3 val=33 id=2", commit_valid, commit_dest, commit_value, commit_RobId); end
    idle(); tick();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL ord_drained got=%b exp=0", commit_valid); end
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < N; i++) begin drive(1, 5'(i + 1), 0, 0, 0, 0, 0); tick(); end
    checks++; if (rob_full !== 1'b1 || issue_RobId !== 4'd0) begin
      failures++; $display("FAIL full_set got full=%b tail=%0d exp full=1 tail=0", rob_full, issue_RobId); end
    drive(1, 5'd20, 0, 0, 0, 0, 0); tick();
    checks++; if (rob_full !== 1'b1 || issue_RobId !== 4'd0) begin
      failures++; $display("FAIL full_drop got full=%b tail=%0d exp full=1 tail=0", rob_full, issue_RobId); end
    drive(0, 0, 1, 4'd0, 32'hA0, 0, 0); tick();
    drive(1, 5'd21, 0, 0, 0, 0, 0); tick();
    checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd0 || commit_value !== 32'hA0 || commit_dest !== 5'd1) begin
      failures++; $display("FAIL full_commit0 got v=%b id=%0d val=%h d=%0d exp v=1 id=0 val=a0 d=1", commit_valid, commit_RobId, commit_value, commit_dest); end
    checks++; if (rob_full !== 1'b0 || issue_RobId !== 4'd0) begin
      failures++; $display("FAIL full_blocked_issue got full=%b tail=%0d exp full=0 tail=0", rob_full, issue_RobId); end
    drive(1, 5'd22, 0, 0, 0, 0, 0); tick();
    checks++; if (rob_full !== 1'b1 || issue_RobId !== 4'd1) begin
      failures++; $display("FAIL full_wrap got full=%b tail=%0d exp full=1 tail=1", rob_full, issue_RobId); end
    drive(0, 0, 1, 4'd1, 32'hB1, 0, 0); tick();
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd1 || rob_full !== 1'b0) begin
      failures++; $display("FAIL full_commit1 got v=%b id=%0d full=%b exp v=1 id=1 full=0", commit_valid, commit_RobId, rob_full); end
  endtask

  task automatic test_mispredict();
    do_reset();
    for (int i = 1; i <= 4; i++) begin drive(1, 5'(i), 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 1, 4'd1, 32'h55, 1, 32'h100); tick();
    drive(0, 0, 1, 4'd0, 32'h10, 0, 0); tick();
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd0 || jump_flag !== 1'b0) begin
      failures++; $display("FAIL mp_commit0 got v=%b id=%0d jf=%b exp v=1 id=0 jf=0", commit_valid, commit_RobId, jump_flag); end
    idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd1 || commit_value !== 32'h55 || jump_flag !== 1'b1 || jump_pc !== 32'h100) begin
      failures++; $display("FAIL mp_jump got v=%b id=%0d val=%h jf=%b pc=%h exp v=1 id=1 val=55 jf=1 pc=100", commit_valid, commit_RobId, commit_value, jump_flag, jump_pc); end
    checks++; if (issue_RobId !== 4'd0 || rob_full !== 1'b0) begin
      failures++; $display("FAIL mp_flushed got tail=%0d full=%b exp tail=0 full=0", issue_RobId, rob_full); end
    query_j_id = 4'd3;
    drive(1, 5'd9, 1, 4'd3, 32'h333, 0, 0); tick();
    checks++; if (jump_flag !== 1'b0 || commit_valid !== 1'b0 || issue_RobId !== 4'd0) begin
      failures++; $display("FAIL mp_after got jf=%b v=%b tail=%0d exp jf=0 v=0 tail=0", jump_flag, commit_valid, issue_RobId); end
    idle();
    checks++; if (query_j_ready !== 1'b0) begin failures++; $display("FAIL mp_late_cdb got ready=%b exp=0", query_j_ready); end
    tick();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL mp_no_commit got=%b exp=0", commit_valid); end
  endtask

  task automatic test_query();
    do_reset();
    for (int i = 1; i <= 2; i++) begin drive(1, 5'(i), 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 1, 4'd0, 32'hABCD, 0, 0); tick();
    query_j_id = 4'd0; query_k_id = 4'd1;
    drive(0, 0, 1, 4'd1, 32'h77, 0, 0);
    checks++; if (query_j_ready !== 1'b1 || query_j_value !== 32'hABCD) begin
      failures++; $display("FAIL q_ready got r=%b v=%h exp r=1 v=abcd", query_j_ready, query_j_value); end
`ifdef ROB_CDB_BYPASS_EN
    checks++; if (query_k_ready !== 1'b1 || query_k_value !== 32'h77) begin
      failures++; $display("FAIL q_bypass got r=%b v=%h exp r=1 v=77", query_k_ready, query_k_value); end
`else
    checks++; if (query_k_ready !== 1'b0 || query_k_value !== 32'h0) begin
      failures++; $display("FAIL q_nobypass got r=%b v=%h exp r=0 v=0", query_k_ready, query_k_value); end
`endif
    tick();
    idle();
    checks++; if (query_k_ready !== 1'b1 || query_k_value !== 32'h77) begin
      failures++; $display("FAIL q_late got r=%b v=%h exp r=1 v=77", query_k_ready, query_k_value); end
    checks++; if (query_j_ready !== 1'b0 || query_j_value !== 32'h0) begin
      failures++; $display("FAIL q_retired got r=%b v=%h exp r=0 v=0", query_j_ready, query_j_value); end
  endtask

  task automatic test_rdy_freeze();
    do_reset();
    for (int i = 1; i <= 3; i++) begin drive(1, 5'(i), 0, 0, 0, 0, 0); tick(); end
    drive(0, 0, 1, 4'd0, 32'h5A, 0, 0); tick();
    drive(0, 0, 1, 4'd1, 32'h6B, 0, 0); tick();
    rdy = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd7, 1, 4'd2, 32'hDEAD, 0, 0); tick();
      checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd0 || issue_RobId !== 4'd3) begin
        failures++; $display("FAIL rdy_hold got v=%b id=%0d tail=%0d exp v=1 id=0 tail=3", commit_valid, commit_RobId, issue_RobId); end
    end
    rdy = 1; idle(); tick();
    checks++; if (commit_valid !== 1'b1 || commit_RobId !== 4'd1 || commit_value !== 32'h6B) begin
      failures++; $display("FAIL rdy_resume got v=%b id=%0d val=%h exp v=1 id=1 val=6b", commit_valid, commit_RobId, commit_value); end
    idle(); tick();
    checks++; if (commit_valid !== 1'b0) begin failures++; $display("FAIL rdy_ignored_cdb got=%b exp=0", commit_valid); end
  endtask

  task automatic test_random();
    bit qr; logic [31:0] qv;
    logic [3:0] cid;
    do_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      rdy = ($urandom_range(0, 9) != 0);
      cid = (mq.size() > 0 && $urandom_range(0, 4) != 0) ? mq[$urandom_range(0, mq.size() - 1)].id : 4'($urandom);
      query_j_id = (mq.size() > 0 && $urandom_range(0, 1) != 0) ? mq[$urandom_range(0, mq.size() - 1)].id : 4'($urandom);
      query_k_id = $urandom_range(0, 1) != 0 ? cid : 4'($urandom);
      drive($urandom_range(0, 2) != 0, 5'($urandom), $urandom_range(0, 1) != 0, cid, $urandom,
            $urandom_range(0, 15) == 0, $urandom);
      qexp(query_j_id, qr, qv);
      checks++; if (query_j_ready !== qr || query_j_value !== qv) begin
        failures++; $display("FAIL rnd_qj cyc=%0d got r=%b v=%h exp r=%b v=%h", cyc, query_j_ready, query_j_value, qr, qv); end
      qexp(query_k_id, qr, qv);
      checks++; if (query_k_ready !== qr || query_k_value !== qv) begin
        failures++; $display("FAIL rnd_qk cyc=%0d got r=%b v=%h exp r=%b v=%h", cyc, query_k_ready, query_k_value, qr, qv); end
      tick();
      checks++; if (commit_valid !== exp_cv || (exp_cv && (commit_dest !== exp_dest || commit_value !== exp_val || commit_RobId !== exp_id))) begin
        failures++; $display("FAIL rnd_commit cyc=%0d got v=%b d=%0d val=%h id=%0d exp v=%b d=%0d val=%h id=%0d",
          cyc, commit_valid, commit_dest, commit_value, commit_RobId, exp_cv, exp_dest, exp_val, exp_id); end
      checks++; if (jump_flag !== exp_jf || (exp_jf && jump_pc !== exp_jpc)) begin
        failures++; $display("FAIL rnd_jump cyc=%0d got jf=%b pc=%h exp jf=%b pc=%h", cyc, jump_flag, jump_pc, exp_jf, exp_jpc); end
      checks++; if (issue_RobId !== m_tail || rob_full !== (mq.size() == N)) begin
        failures++; $display("FAIL rnd_alloc cyc=%0d got tail=%0d full=%b exp tail=%0d full=%b", cyc, issue_RobId, rob_full, m_tail, mq.size() == N); end
    end
  endtask

  initial begin
    clk = 0; rst_n = 0; rdy = 1;
    issue_valid = 0; issue_rd = 0; cdb_valid = 0; cdb_RobId = 0; cdb_value = 0;
    cdb_jump = 0; cdb_target = 0; query_j_id = 0; query_k_id = 0;
    model_reset();
    #3;
    test_reset();
    test_in_order();
    test_full_wrap();
    test_reset();
    test_mispredict();
    test_query();
    test_rdy_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
